// File: rtl/nios_system_button_pio.sv
// Debounced, interrupt-capable Avalon-MM input PIO for pushbuttons.
// Read latency 1 clk; input-to-q latency SYNC_STAGES (+ DEBOUNCE_CYCLES when filtered).
// No backpressure: slave always accepts. Define PIO_DEBOUNCE_EN to build the debounce filter.
module nios_system_button_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Reject nonsensical configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("nios_system_button_pio: parameter out of range");
  end

  logic                              wr_en;
  logic [WIDTH-1:0]                  wr_val;
  logic                              unused_wdata;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  q;
  logic [WIDTH-1:0]                  q_d;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  events;
  logic [WIDTH-1:0]                  rise_en;
  logic [WIDTH-1:0]                  irq_mask;
  logic [WIDTH-1:0]                  fall_en;
  logic [WIDTH-1:0]                  edge_capture;

  assign wr_en        = chipselect && !write_n;
  assign wr_val       = writedata[WIDTH-1:0];
  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  // Metastability synchroniser: stage 0 samples the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  // Per-bit filter: q follows s only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          q[i]   <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign q = s;
`endif

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_d <= '0;
    else          q_d <= q;
  end

  assign rise   = q & ~q_d;
  assign fall   = ~q & q_d;
  assign events = (rise & rise_en) | (fall & fall_en);

  // Control registers; fall_en resets to ones because the buttons are active-low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '0;
      irq_mask <= '0;
      fall_en  <= '1;
    end else if (wr_en) begin
      case (address)
        3'd1:    rise_en  <= wr_val;
        3'd2:    irq_mask <= wr_val;
        3'd4:    fall_en  <= wr_val;
        default: ;
      endcase
    end
  end

  // Sticky edge capture with write-1-to-clear; a same-cycle event wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_en && address == 3'd3) begin
      edge_capture <= (edge_capture & ~wr_val) | events;
    end else begin
      edge_capture <= edge_capture | events;
    end
  end

  // Registered read mux, refreshed every cycle from address alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        3'd0:    readdata <= 32'(q);
        3'd1:    readdata <= 32'(rise_en);
        3'd2:    readdata <= 32'(irq_mask);
        3'd3:    readdata <= 32'(edge_capture);
        3'd4:    readdata <= 32'(fall_en);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_system_button_pio.sv
// Randomised + directed bench for nios_system_button_pio against a behavioural model.
// The model tracks the filtered level as "last N synchronised samples all agree".
// Works with PIO_DEBOUNCE_EN defined or undefined.
module tb_nios_system_button_pio;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef PIO_DEBOUNCE_EN
  localparam int WIN  = DEB;
  localparam int DLY  = SYNC;
`else
  localparam int WIN  = 1;
  localparam int DLY  = SYNC - 1;
`endif
  localparam int Q_LAT   = DLY + WIN;
  localparam int CAP_LAT = Q_LAT + 1;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  nios_system_button_pio #(
    .WIDTH(4),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0]  m_q, m_qd, m_cap, m_rise, m_mask, m_fall;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [3:0]  rawq[$];
  logic [3:0]  shist[$];
  logic [3:0]  cur_pin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rawq.delete();
    shist.delete();
    for (int i = 0; i < DLY; i++) rawq.push_back(4'h0);
    for (int i = 0; i < WIN; i++) shist.push_back(4'h0);
    m_q = 0; m_qd = 0; m_cap = 0; m_rise = 0; m_mask = 0; m_fall = 4'hF;
    m_rd = 0; m_irq = 0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge values.
  task automatic model_edge(input logic [2:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] pin);
    logic [3:0] ev, sv;
    bit same;
    ev = (m_q & ~m_qd & m_rise) | (~m_q & m_qd & m_fall);
    case (a)
      3'd0: m_rd = {28'h0, m_q};
      3'd1: m_rd = {28'h0, m_rise};
      3'd2: m_rd = {28'h0, m_mask};
      3'd3: m_rd = {28'h0, m_cap};
      3'd4: m_rd = {28'h0, m_fall};
      default: m_rd = 0;
    endcase
    if (we) begin
      case (a)
        3'd1: m_rise = wd[3:0];
        3'd2: m_mask = wd[3:0];
        3'd3: m_cap  = m_cap & ~wd[3:0];
        3'd4: m_fall = wd[3:0];
        default: ;
      endcase
    end
    m_cap = m_cap | ev;
    rawq.push_back(pin);
    sv = rawq.pop_front();
    shist.push_back(sv);
    if (shist.size() > WIN) void'(shist.pop_front());
    m_qd = m_q;
    for (int b = 0; b < 4; b++) begin
      same = 1;
      foreach (shist[k]) if (shist[k][b] != sv[b]) same = 0;
      if (same) m_q[b] = sv[b];
    end
    m_irq = |(m_cap & m_mask);
  endtask

  task automatic step(input logic [2:0] a, input logic we, input logic [31:0] wd);
    address    = a;
    chipselect = we ? 1'b1 : 1'($urandom_range(0, 1));
    write_n    = ~we;
    writedata  = wd;
    in_port    = cur_pin;
    model_edge(a, we, wd, cur_pin);
    @(posedge clk);
    @(negedge clk);
    chk("readdata", readdata, m_rd);
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 1'b0, $urandom);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    step(a, 1'b0, $urandom);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    step(a, 1'b1, d);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", {31'h0, irq}, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    clk = 0; reset_n = 0; address = 0; chipselect = 0; write_n = 1;
    writedata = 0; in_port = 0; cur_pin = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Reset values of the register map
    for (int a = 0; a < 5; a++) begin
      rd_reg(3'(a));
      chk($sformatf("reset_addr%0d", a), readdata, (a == 4) ? 32'hF : 32'h0);
    end

    // Buttons released: q follows after the filter latency, no capture
    cur_pin = 4'hF;
    idle(Q_LAT - 1);
    rd_reg(3'd0);
    chk("q_before_latency", readdata, 32'h0);
    rd_reg(3'd0);
    chk("q_after_latency", readdata, 32'hF);
    rd_reg(3'd3);
    chk("no_rise_capture", readdata, 32'h0);

    // Glitch of DEB-1 cycles on bit0
    cur_pin = 4'hE;
    idle(DEB - 1);
    cur_pin = 4'hF;
    idle(12);
    rd_reg(3'd0);
    chk("glitch_q", readdata, 32'hF);
    rd_reg(3'd3);
`ifdef PIO_DEBOUNCE_EN
    chk("glitch_cap", readdata, 32'h0);
`else
    chk("glitch_cap", readdata, 32'h1);
`endif
    chk("glitch_irq", {31'h0, irq}, 0);
    wr_reg(3'd3, 32'hF);

    // Falling capture with irq latency measurement
    wr_reg(3'd2, 32'h1);
    cur_pin = 4'hE;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!irq && n < 40);
    chk("fall_irq_latency", n, CAP_LAT);
    rd_reg(3'd3);
    chk("fall_cap", readdata, 32'h1);
    rd_reg(3'd0);
    chk("fall_q", readdata, 32'hE);

    // Rising-only on bit1
    wr_reg(3'd1, 32'h2);
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd3, 32'hF);
    cur_pin = 4'hC;
    idle(20);
    rd_reg(3'd3);
    chk("press_no_cap", readdata, 32'h0);
    cur_pin = 4'hE;
    idle(CAP_LAT);
    rd_reg(3'd3);
    chk("release_cap", readdata, 32'h2);

    // W1C and set-wins collision
    wr_reg(3'd1, 32'h3);
    cur_pin = 4'hF;
    idle(CAP_LAT);
    rd_reg(3'd3);
    chk("cap_both", readdata, 32'h3);
    wr_reg(3'd3, 32'h1);
    chk("w1c_irq_low", {31'h0, irq}, 0);
    rd_reg(3'd3);
    chk("w1c_cap", readdata, 32'h2);
    wr_reg(3'd4, 32'h1);
    cur_pin = 4'hE;
    idle(CAP_LAT - 1);
    wr_reg(3'd3, 32'h1);
    chk("collision_irq", {31'h0, irq}, 1);
    rd_reg(3'd3);
    chk("collision_cap", readdata, 32'h3);

    // Reset in the middle of a debounce window
    cur_pin = 4'hF;
    idle(SYNC + 5);
    @(negedge clk);
    do_reset();
    rd_reg(3'd0);
    chk("post_rst_q", readdata, 32'h0);
    rd_reg(3'd3);
    chk("post_rst_cap", readdata, 32'h0);
    idle(Q_LAT);
    rd_reg(3'd0);
    chk("post_rst_q_settled", readdata, 32'hF);
    rd_reg(3'd3);
    chk("post_rst_no_spurious", readdata, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cur_pin = 4'($urandom);
      if ($urandom_range(0, 7) == 0) step(3'($urandom), 1'b1, $urandom);
      else                           rd_reg(3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
